fifo_wr_arbiter: RTL and testbench

//  Round-robin write-port arbiter for the FIFO memory: shares the single winc/wdata write port between

---
 rtl/fifo_wr_arbiter_pkg.sv | 22 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// definitions : shared FIFO widths plus write-arbiter defaults and state type.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package definitions;

  localparam int DATASIZE      = 8;
  localparam int ADDRSIZE      = 4;

  localparam int NREQ_DEF      = 4;
  localparam int BURST_MAX_DEF = 8;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational rotate-priority picker, scanning from last_i+1 upward.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic            any_o,
  output logic [IW-1:0]   idx_o
);

  always_comb begin : p_pick
    int            cand;
    logic [IW-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    any_o    = 1'b0;
    idx_o    = '0;
    // The candidate after last_i gets top priority; last_i itself is tried last.
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(last_i) + k) % NREQ;
      cand_idx = IW'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o = 1'b1;
        idx_o = cand_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter : round-robin burst arbiter sharing the FIFO write port.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_wr_arbiter #(
  parameter int DATASIZE  = definitions::DATASIZE,
  parameter int NREQ      = definitions::NREQ_DEF,
  parameter int BURST_MAX = definitions::BURST_MAX_DEF,
  parameter int CNTW      = 16
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic                     winc,
  output logic [DATASIZE-1:0]      wdata,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     busy,
  output logic [CNTW-1:0]          wr_count
);

  import definitions::*;

  localparam int             IW         = $clog2(NREQ);
  localparam int             BCW        = $clog2(BURST_MAX + 1);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_MAX - 1);
  localparam logic [IW-1:0]  LAST_RST   = IW'(NREQ - 1);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic [BCW-1:0]  burst_cnt_q, burst_cnt_d;
  logic [CNTW-1:0] wr_count_q, wr_count_d;

  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic            gnt_valid;
  logic            xfer;
  logic            burst_done;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  // winc is purely combinational so the FIFO's registered wfull gates it in the same cycle.
  assign gnt_valid  = req_valid[gnt_q];
  assign xfer       = (state_q == ARB_BURST) && gnt_valid && !wfull;
  assign burst_done = xfer && (burst_cnt_q == BURST_LAST);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (burst_done || !gnt_valid) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == ARB_BURST);
    winc      = xfer;
    wdata     = req_data[int'(gnt_q)*DATASIZE +: DATASIZE];
    req_ready = '0;
    if (state_q == ARB_BURST) begin
      req_ready[gnt_q] = !wfull;
    end
  end

  always_comb begin
    gnt_d       = gnt_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    wr_count_d  = wr_count_q;

    if (state_q == ARB_IDLE && pick_any) begin
      gnt_d       = pick_idx;
      last_d      = pick_idx;
      burst_cnt_d = '0;
    end

    // Clearing on release keeps the registered count strictly below BURST_MAX.
    if (state_q == ARB_BURST) begin
      if (burst_done || !gnt_valid) begin
        burst_cnt_d = '0;
      end else if (xfer) begin
        burst_cnt_d = burst_cnt_q + BCW'(1);
      end
    end

    if (xfer) begin
      wr_count_d = wr_count_q + CNTW'(1);
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      gnt_q       <= '0;
      last_q      <= LAST_RST;
      burst_cnt_q <= '0;
      wr_count_q  <= '0;
    end else begin
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign gnt_id   = gnt_q;
  assign wr_count = wr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter : directed scenario bench for the FIFO write arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fifo_wr_arbiter;

  import definitions::*;

  localparam int DW = DATASIZE;
  localparam int NR = 4;
  localparam int BM = 8;
  localparam int CW = 16;

  logic             wclk = 1'b0;
  logic             wrst_n = 1'b0;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             wfull;
  logic             winc;
  logic [DW-1:0]    wdata;
  logic [1:0]       gnt_id;
  logic             busy;
  logic [CW-1:0]    wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wr_arbiter #(
    .DATASIZE  (DW),
    .NREQ      (NR),
    .BURST_MAX (BM),
    .CNTW      (CW)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .wr_count  (wr_count)
  );

  always #5 wclk = ~wclk;

  function automatic logic [DW-1:0] exp_data(input int i);
    return DW'(9 + 17 * i);
  endfunction

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic apply_reset();
    wrst_n = 1'b0;
    @(posedge wclk);
    #3;
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    wfull     = 1'b0;
    wrst_n    = 1'b0;
    #2;
    n_checks++; if (winc !== 1'b0) begin n_fail++; $display("FAIL reset_winc: got %b want 0", winc); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
    n_checks++; if (gnt_id !== 2'd0) begin n_fail++; $display("FAIL reset_gnt: got %0d want 0", gnt_id); end
    @(posedge wclk);
    #2;
    n_checks++; if (winc !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got winc=%b busy=%b want 0/0", winc, busy); end
    #1;
    wrst_n = 1'b1;
    step();
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_grant_busy: got %b want 1", busy); end
    n_checks++; if (gnt_id !== 2'd0) begin n_fail++; $display("FAIL first_grant_id: got %0d want 0", gnt_id); end
  endtask

  task automatic test_fairness();
    logic [NR-1:0] exp_rdy;
    req_valid = '1;
    wfull     = 1'b0;
    apply_reset();
    for (int g = 0; g < 8; g++) begin
      exp_rdy = 4'b0001 << (g % NR);
      step();
      #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fair_busy g%0d: got %b want 1", g, busy); end
      n_checks++; if (gnt_id !== 2'(g % NR)) begin n_fail++; $display("FAIL fair_gnt g%0d: got %0d want %0d", g, gnt_id, g % NR); end
      for (int w = 0; w < BM; w++) begin
        if (w > 0) begin
          step();
          #1;
        end
        n_checks++; if (winc !== 1'b1) begin n_fail++; $display("FAIL fair_winc g%0d w%0d: got %b want 1", g, w, winc); end
        n_checks++; if (wdata !== exp_data(g % NR)) begin n_fail++; $display("FAIL fair_wdata g%0d w%0d: got %h want %h", g, w, wdata, exp_data(g % NR)); end
        n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL fair_ready g%0d w%0d: got %b want %b", g, w, req_ready, exp_rdy); end
      end
      step();
      #1;
      n_checks++; if (busy !== 1'b0 || winc !== 1'b0) begin n_fail++; $display("FAIL fair_idle g%0d: got busy=%b winc=%b want 0/0", g, busy, winc); end
    end
    n_checks++; if (wr_count !== 16'd64) begin n_fail++; $display("FAIL fair_wr_count: got %0d want 64", wr_count); end
  endtask

  task automatic test_burst_limit();
    int lens[$];
    int run;
    int gap;
    int words;
    bit drop;
    bit gnt_ok;
    run    = 0;
    gap    = 0;
    words  = 0;
    drop   = 1'b0;
    gnt_ok = 1'b1;
    req_valid = 4'b0100;
    wfull     = 1'b0;
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      step();
      if (drop) req_valid = '0;
      #1;
      if (busy && gnt_id !== 2'd2) gnt_ok = 1'b0;
      if (winc) begin
        if (run == 0 && words > 0) begin
          n_checks++; if (gap !== 1) begin n_fail++; $display("FAIL burst_gap: got %0d idle cycles want 1", gap); end
        end
        run++;
        words++;
        gap = 0;
        if (words == 20) drop = 1'b1;
      end else if (!busy) begin
        if (run > 0) begin
          lens.push_back(run);
          run = 0;
        end
        gap++;
      end
    end
    n_checks++; if (lens.size() !== 3) begin n_fail++; $display("FAIL burst_count: got %0d bursts want 3", lens.size()); end
    n_checks++; if (lens[0] !== 8) begin n_fail++; $display("FAIL burst_len0: got %0d want 8", lens[0]); end
    n_checks++; if (lens[1] !== 8) begin n_fail++; $display("FAIL burst_len1: got %0d want 8", lens[1]); end
    n_checks++; if (lens[2] !== 4) begin n_fail++; $display("FAIL burst_len2: got %0d want 4", lens[2]); end
    n_checks++; if (words !== 20) begin n_fail++; $display("FAIL burst_words: got %0d want 20", words); end
    n_checks++; if (wr_count !== 16'd20) begin n_fail++; $display("FAIL burst_wr_count: got %0d want 20", wr_count); end
    n_checks++; if (gnt_ok !== 1'b1) begin n_fail++; $display("FAIL burst_gnt: got grant other than 2 want only 2"); end
  endtask

  task automatic test_full_stall();
    int words;
    req_valid = 4'b0001;
    wfull     = 1'b0;
    apply_reset();
    step();
    for (int w = 0; w < 3; w++) begin
      #1;
      n_checks++; if (winc !== 1'b1) begin n_fail++; $display("FAIL stall_pre_winc w%0d: got %b want 1", w, winc); end
      step();
    end
    for (int k = 0; k < 5; k++) begin
      wfull = 1'b1;
      #1;
      n_checks++; if (winc !== 1'b0) begin n_fail++; $display("FAIL stall_winc k%0d: got %b want 0", k, winc); end
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready k%0d: got %b want 0000", k, req_ready); end
      n_checks++; if (gnt_id !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_grant k%0d: got gnt=%0d busy=%b want 0/1", k, gnt_id, busy); end
      n_checks++; if (wr_count !== 16'd3) begin n_fail++; $display("FAIL stall_count k%0d: got %0d want 3", k, wr_count); end
      step();
    end
    wfull = 1'b0;
    words = 3;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (winc) words++;
      if (!busy) break;
      step();
    end
    n_checks++; if (words !== 8) begin n_fail++; $display("FAIL stall_burst_words: got %0d want 8", words); end
    n_checks++; if (wr_count !== 16'd8) begin n_fail++; $display("FAIL stall_wr_count: got %0d want 8", wr_count); end
  endtask

  task automatic test_valid_gap();
    req_valid = 4'b1010;
    wfull     = 1'b0;
    apply_reset();
    step();
    for (int w = 0; w < 3; w++) begin
      #1;
      n_checks++; if (gnt_id !== 2'd1 || winc !== 1'b1) begin n_fail++; $display("FAIL gap_req1 w%0d: got gnt=%0d winc=%b want 1/1", w, gnt_id, winc); end
      n_checks++; if (wdata !== exp_data(1)) begin n_fail++; $display("FAIL gap_wdata1 w%0d: got %h want %h", w, wdata, exp_data(1)); end
      step();
    end
    req_valid = 4'b1000;
    #1;
    n_checks++; if (winc !== 1'b0) begin n_fail++; $display("FAIL gap_drop_winc: got %b want 0", winc); end
    step();
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gap_release: got busy=%b want 0", busy); end
    step();
    #1;
    n_checks++; if (gnt_id !== 2'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL gap_regrant: got gnt=%0d busy=%b want 3/1", gnt_id, busy); end
    n_checks++; if (winc !== 1'b1 || wdata !== exp_data(3)) begin n_fail++; $display("FAIL gap_wdata3: got winc=%b wdata=%h want 1/%h", winc, wdata, exp_data(3)); end
    n_checks++; if (wr_count !== 16'd3) begin n_fail++; $display("FAIL gap_wr_count: got %0d want 3", wr_count); end
  endtask

  task automatic test_async_reset();
    req_valid = '1;
    wfull     = 1'b0;
    apply_reset();
    step();
    for (int w = 0; w < 4; w++) begin
      #1;
      n_checks++; if (winc !== 1'b1) begin n_fail++; $display("FAIL areset_pre_winc w%0d: got %b want 1", w, winc); end
      step();
    end
    #1;
    n_checks++; if (wr_count !== 16'd4 || winc !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got count=%0d winc=%b want 4/1", wr_count, winc); end
    wrst_n = 1'b0;
    #1;
    n_checks++; if (winc !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL areset_abort: got winc=%b busy=%b want 0/0", winc, busy); end
    n_checks++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL areset_count: got %0d want 0", wr_count); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL areset_ready: got %b want 0000", req_ready); end
    @(posedge wclk);
    #3;
    wrst_n = 1'b1;
    step();
    #1;
    n_checks++; if (gnt_id !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL areset_restart: got gnt=%0d busy=%b want 0/1", gnt_id, busy); end
  endtask

  initial begin
    req_valid = '0;
    wfull     = 1'b0;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = exp_data(i);
    test_reset();
    test_fairness();
    test_burst_limit();
    test_full_stall();
    test_valid_gap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
